// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the single-port memory arbiter
package mem_arb_pkg;

  // Which requester owns the response arriving in the current cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } mem_own_e;

  // Starvation counter width; bounds STARVE_MAX to 1..15
  localparam int SCNT_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - data-priority grant decision with fetch starvation guard
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_if_gnt,
  output logic o_d_gnt
);

  localparam logic [SCNT_W-1:0] LP_STARVE_MAX = SCNT_W'(STARVE_MAX);

  logic [SCNT_W-1:0] r_scnt;
  logic              w_d_gnt;
  logic              w_if_gnt;

  // Data wins unless fetch has waited through STARVE_MAX data grants; nothing is granted in reset
  always_comb begin
    w_d_gnt  = !rst && i_d_req && ((r_scnt < LP_STARVE_MAX) || !i_if_req);
    w_if_gnt = !rst && i_if_req && !w_d_gnt;
  end

  // Count data grants taken while fetch waits; a data grant with fetch pending implies scnt < max
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt <= '0;
    end else if (w_if_gnt || !i_if_req) begin
      r_scnt <= '0;
    end else if (w_d_gnt) begin
      r_scnt <= r_scnt + 1'b1;
    end
  end

  assign o_if_gnt = w_if_gnt;
  assign o_d_gnt  = w_d_gnt;

endmodule

// File: rtl/mem_arb_sp.sv
// rtl/mem_arb_sp.sv - fetch/load-store arbiter in front of a 1-cycle single-port memory
module mem_arb_sp
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_if_req,
  input  logic [DATA_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  input  logic                  i_d_req,
  input  logic [DATA_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  input  logic [DATA_BYTES-1:0] i_d_wen,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [DATA_BYTES-1:0] o_mem_wen,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  logic                  w_if_gnt;
  logic                  w_d_gnt;
  logic [DATA_WIDTH-1:0] w_mem_addr;
  logic [DATA_BYTES-1:0] w_mem_wen;
  logic [DATA_WIDTH-1:0] r_last_addr;
  mem_own_e              r_own;

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (i_if_req),
    .i_d_req  (i_d_req),
    .o_if_gnt (w_if_gnt),
    .o_d_gnt  (w_d_gnt)
  );

  // Steer the granted request onto the memory; idle cycles re-read the last address
  always_comb begin
    w_mem_addr = r_last_addr;
    w_mem_wen  = '0;
    if (rst) begin
      w_mem_addr = '0;
    end else if (w_d_gnt) begin
      w_mem_addr = i_d_addr;
      w_mem_wen  = i_d_wen;
    end else if (w_if_gnt) begin
      w_mem_addr = i_if_addr;
    end
  end

  // Remember who owns next cycle's read data and the address last driven
  always_ff @(posedge clk) begin
    if (rst) begin
      r_own       <= OWN_NONE;
      r_last_addr <= '0;
    end else begin
      r_last_addr <= w_mem_addr;
      if (w_d_gnt) begin
        r_own <= OWN_D;
      end else if (w_if_gnt) begin
        r_own <= OWN_IF;
      end else begin
        r_own <= OWN_NONE;
      end
    end
  end

  assign o_if_gnt    = w_if_gnt;
  assign o_d_gnt     = w_d_gnt;
  assign o_mem_addr  = w_mem_addr;
  assign o_mem_wdata = i_d_wdata;
  assign o_mem_wen   = w_mem_wen;

  // Reset drops any response already in flight
  assign o_if_rvalid = !rst && (r_own == OWN_IF);
  assign o_d_rvalid  = !rst && (r_own == OWN_D);
  assign o_if_rdata  = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;

endmodule
